// File: rtl/exec_ctrl_unit.sv
// RV32I decode control, D->E pipeline register, branch resolver and ALU.
// E outputs follow D inputs one edge later; alu_out and pcsel are combinational in E.
module exec_ctrl_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [6:0]      opcode_d,
    input  logic [2:0]      funct3_d,
    input  logic [6:0]      funct7_d,
    input  logic [XLEN-1:0] imm_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] rs1_data_e,
    input  logic [XLEN-1:0] rs2_data_e,
    output logic [XLEN-1:0] alu_out,
    output logic            pcsel,
    output logic            regwen_e,
    output logic            memrw_e,
    output logic [1:0]      wbsel_e,
    output logic [1:0]      size_e,
    output logic [2:0]      funct3_e
);

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    // Decode-stage control word
    logic       regwen_d, memrw_d, asel_d, bsel_d, brun_d;
    logic [1:0] wbsel_d, size_d;

    // E-stage state
    logic [6:0]      opcode_e;
    logic            alt_e;
    logic            asel_e, bsel_e, brun_e;
    logic [XLEN-1:0] imm_e, pc_e;

    // Only funct7[5] distinguishes sub/sra in RV32I
    logic unused_funct7;
    assign unused_funct7 = ^{funct7_d[6], funct7_d[4:0]};

    always_comb begin
        regwen_d = 1'b0;
        memrw_d  = 1'b0;
        asel_d   = 1'b0;
        bsel_d   = 1'b0;
        brun_d   = 1'b0;
        wbsel_d  = 2'd0;
        size_d   = 2'd0;
        case (opcode_d)
            OP_LUI: begin
                regwen_d = 1'b1; bsel_d = 1'b1; wbsel_d = 2'd1;
            end
            OP_AUIPC: begin
                regwen_d = 1'b1; asel_d = 1'b1; bsel_d = 1'b1; wbsel_d = 2'd1;
            end
            OP_JAL: begin
                regwen_d = 1'b1; asel_d = 1'b1; bsel_d = 1'b1; wbsel_d = 2'd2;
            end
            OP_JALR: begin
                regwen_d = 1'b1; bsel_d = 1'b1; wbsel_d = 2'd2;
            end
            OP_BRANCH: begin
                asel_d = 1'b1; bsel_d = 1'b1; brun_d = funct3_d[1];
            end
            OP_LOAD: begin
                regwen_d = 1'b1; bsel_d = 1'b1; wbsel_d = 2'd0; size_d = funct3_d[1:0];
            end
            OP_STORE: begin
                memrw_d = 1'b1; bsel_d = 1'b1; size_d = funct3_d[1:0];
            end
            OP_IMM: begin
                regwen_d = 1'b1; bsel_d = 1'b1; wbsel_d = 2'd1;
            end
            OP_REG: begin
                regwen_d = 1'b1; wbsel_d = 2'd1;
            end
            default: ;
        endcase
    end

    // Stall and flush both insert an opcode-0 bubble, which decodes to no side effects
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opcode_e <= '0;
            funct3_e <= '0;
            alt_e    <= 1'b0;
            imm_e    <= '0;
            pc_e     <= '0;
            regwen_e <= 1'b0;
            memrw_e  <= 1'b0;
            asel_e   <= 1'b0;
            bsel_e   <= 1'b0;
            brun_e   <= 1'b0;
            wbsel_e  <= '0;
            size_e   <= '0;
        end else if (stall || flush) begin
            opcode_e <= '0;
            funct3_e <= '0;
            alt_e    <= 1'b0;
            imm_e    <= '0;
            pc_e     <= '0;
            regwen_e <= 1'b0;
            memrw_e  <= 1'b0;
            asel_e   <= 1'b0;
            bsel_e   <= 1'b0;
            brun_e   <= 1'b0;
            wbsel_e  <= '0;
            size_e   <= '0;
        end else begin
            opcode_e <= opcode_d;
            funct3_e <= funct3_d;
            alt_e    <= funct7_d[5];
            imm_e    <= imm_d;
            pc_e     <= pc_d;
            regwen_e <= regwen_d;
            memrw_e  <= memrw_d;
            asel_e   <= asel_d;
            bsel_e   <= bsel_d;
            brun_e   <= brun_d;
            wbsel_e  <= wbsel_d;
            size_e   <= size_d;
        end
    end

    logic [XLEN-1:0] in_a, in_b, sum;
    logic [4:0]      shamt;

    assign in_a  = asel_e ? pc_e : rs1_data_e;
    assign in_b  = bsel_e ? imm_e : rs2_data_e;
    assign sum   = in_a + in_b;
    assign shamt = in_b[4:0];

    always_comb begin
        alu_out = '0;
        case (opcode_e)
            OP_LUI: alu_out = in_b;
            OP_AUIPC, OP_JAL, OP_BRANCH, OP_LOAD, OP_STORE: alu_out = sum;
            OP_JALR: alu_out = sum & ~XLEN'(1);
            OP_IMM, OP_REG: begin
                case (funct3_e)
                    3'd0: alu_out = (opcode_e == OP_REG && alt_e) ? in_a - in_b : sum;
                    3'd1: alu_out = in_a << shamt;
                    3'd2: alu_out = XLEN'($signed(in_a) < $signed(in_b));
                    3'd3: alu_out = XLEN'(in_a < in_b);
                    3'd4: alu_out = in_a ^ in_b;
                    3'd5: alu_out = alt_e ? XLEN'($signed(in_a) >>> shamt) : in_a >> shamt;
                    3'd6: alu_out = in_a | in_b;
                    default: alu_out = in_a & in_b;
                endcase
            end
            default: ;
        endcase
    end

    // Branches compare the raw register values, not the pc/imm operand muxes
    logic br_eq, br_lt, br_taken;

    assign br_eq = (rs1_data_e == rs2_data_e);
    assign br_lt = brun_e ? (rs1_data_e < rs2_data_e)
                          : ($signed(rs1_data_e) < $signed(rs2_data_e));

    always_comb begin
        br_taken = 1'b0;
        case (funct3_e)
            3'd0: br_taken = br_eq;
            3'd1: br_taken = !br_eq;
            3'd4, 3'd6: br_taken = br_lt;
            3'd5, 3'd7: br_taken = !br_lt;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        pcsel = 1'b0;
        case (opcode_e)
            OP_JAL, OP_JALR: pcsel = 1'b1;
            OP_BRANCH: pcsel = br_taken;
            default: pcsel = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Directed vector bench for exec_ctrl_unit: table of single-instruction vectors
// plus hand-written stall/flush/async-reset sequences.
module tb_exec_ctrl_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [6:0]  opcode_d;
    logic [2:0]  funct3_d;
    logic [6:0]  funct7_d;
    logic [31:0] imm_d;
    logic [31:0] pc_d;
    logic [31:0] rs1_data_e;
    logic [31:0] rs2_data_e;
    logic [31:0] alu_out;
    logic        pcsel;
    logic        regwen_e;
    logic        memrw_e;
    logic [1:0]  wbsel_e;
    logic [1:0]  size_e;
    logic [2:0]  funct3_e;

    exec_ctrl_unit #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .opcode_d(opcode_d), .funct3_d(funct3_d), .funct7_d(funct7_d),
        .imm_d(imm_d), .pc_d(pc_d),
        .rs1_data_e(rs1_data_e), .rs2_data_e(rs2_data_e),
        .alu_out(alu_out), .pcsel(pcsel), .regwen_e(regwen_e), .memrw_e(memrw_e),
        .wbsel_e(wbsel_e), .size_e(size_e), .funct3_e(funct3_e)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] e_alu;
        logic [9:0]  e_ctrl;   // {pcsel, regwen, memrw, wbsel, size, funct3}
    } vec_t;

    vec_t  vecs[64];
    string names[64];
    int    n_vec;

    int tests_run;
    int tests_failed;

    logic [41:0] exp_q[$];

    function automatic logic [9:0] ctrl(input logic p, input logic rw, input logic mw,
                                        input logic [1:0] wb, input logic [1:0] sz,
                                        input logic [2:0] f3);
        return {p, rw, mw, wb, sz, f3};
    endfunction

    task automatic add_vec(input string n, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] pc,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] e_alu, input logic [9:0] e_ctrl);
        vecs[n_vec].op     = op;
        vecs[n_vec].f3     = f3;
        vecs[n_vec].f7     = f7;
        vecs[n_vec].imm    = imm;
        vecs[n_vec].pc     = pc;
        vecs[n_vec].rs1    = rs1;
        vecs[n_vec].rs2    = rs2;
        vecs[n_vec].e_alu  = e_alu;
        vecs[n_vec].e_ctrl = e_ctrl;
        names[n_vec]       = n;
        n_vec++;
    endtask

    // Driver tasks
    task automatic drive_d(input logic s, input logic f, input logic [6:0] op,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm, input logic [31:0] pc);
        stall    = s;
        flush    = f;
        opcode_d = op;
        funct3_d = f3;
        funct7_d = f7;
        imm_d    = imm;
        pc_d     = pc;
    endtask

    task automatic drive_rs(input logic [31:0] rs1, input logic [31:0] rs2);
        rs1_data_e = rs1;
        rs2_data_e = rs2;
    endtask

    // Scoreboard
    task automatic expect_e(input logic [31:0] e_alu, input logic [9:0] e_ctrl);
        exp_q.push_back({e_alu, e_ctrl});
    endtask

    task automatic check_e(input string n);
        logic [41:0] exp_v;
        logic [9:0]  act_ctrl;
        act_ctrl = {pcsel, regwen_e, memrw_e, wbsel_e, size_e, funct3_e};
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: no expected entry queued", n);
            return;
        end
        exp_v = exp_q.pop_front();
        tests_run++;
        if (alu_out !== exp_v[41:10]) begin
            tests_failed++;
            $display("FAIL %s alu_out: got %h expected %h", n, alu_out, exp_v[41:10]);
        end
        tests_run++;
        if (act_ctrl !== exp_v[9:0]) begin
            tests_failed++;
            $display("FAIL %s ctrl{pcsel,regwen,memrw,wbsel,size,f3}: got %b expected %b",
                     n, act_ctrl, exp_v[9:0]);
        end
    endtask

    localparam logic [9:0] ZERO_CTRL = 10'b0;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        n_vec        = 0;

        //        name      op     f3    f7     imm           pc            rs1           rs2           alu           {pcsel,regwen,memrw,wb,size,f3}
        add_vec("add",    7'h33, 3'd0, 7'h00, 32'h0,        32'h0,        32'd5,        32'd7,        32'd12,       ctrl(0,1,0,2'd1,2'd0,3'd0));
        add_vec("sub",    7'h33, 3'd0, 7'h20, 32'h0,        32'h0,        32'h80000000, 32'd4,        32'h7FFFFFFC, ctrl(0,1,0,2'd1,2'd0,3'd0));
        add_vec("sra",    7'h33, 3'd5, 7'h20, 32'h0,        32'h0,        32'h80000000, 32'd4,        32'hF8000000, ctrl(0,1,0,2'd1,2'd0,3'd5));
        add_vec("srl",    7'h33, 3'd5, 7'h00, 32'h0,        32'h0,        32'h80000000, 32'd4,        32'h08000000, ctrl(0,1,0,2'd1,2'd0,3'd5));
        add_vec("addi_f7",7'h13, 3'd0, 7'h20, 32'd4,        32'h0,        32'h80000000, 32'd99,       32'h80000004, ctrl(0,1,0,2'd1,2'd0,3'd0));
        add_vec("slli",   7'h13, 3'd1, 7'h00, 32'h24,       32'h0,        32'd1,        32'd0,        32'h10,       ctrl(0,1,0,2'd1,2'd0,3'd1));
        add_vec("slt",    7'h33, 3'd2, 7'h00, 32'h0,        32'h0,        32'hFFFFFFFF, 32'd1,        32'd1,        ctrl(0,1,0,2'd1,2'd0,3'd2));
        add_vec("sltu",   7'h33, 3'd3, 7'h00, 32'h0,        32'h0,        32'hFFFFFFFF, 32'd1,        32'd0,        ctrl(0,1,0,2'd1,2'd0,3'd3));
        add_vec("xor",    7'h33, 3'd4, 7'h00, 32'h0,        32'h0,        32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, ctrl(0,1,0,2'd1,2'd0,3'd4));
        add_vec("or",     7'h33, 3'd6, 7'h00, 32'h0,        32'h0,        32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, ctrl(0,1,0,2'd1,2'd0,3'd6));
        add_vec("and",    7'h33, 3'd7, 7'h00, 32'h0,        32'h0,        32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, ctrl(0,1,0,2'd1,2'd0,3'd7));
        add_vec("add_wrap",7'h33,3'd0, 7'h00, 32'h0,        32'h0,        32'hFFFFFFFF, 32'd2,        32'd1,        ctrl(0,1,0,2'd1,2'd0,3'd0));
        add_vec("lui",    7'h37, 3'd0, 7'h00, 32'h12345000, 32'h0,        32'h11111111, 32'h0,        32'h12345000, ctrl(0,1,0,2'd1,2'd0,3'd0));
        add_vec("auipc",  7'h17, 3'd0, 7'h00, 32'h00002000, 32'h00001000, 32'h11111111, 32'h0,        32'h00003000, ctrl(0,1,0,2'd1,2'd0,3'd0));
        add_vec("bltu",   7'h63, 3'd6, 7'h00, 32'hFFFFFFF8, 32'h01000010, 32'd1,        32'hFFFFFFFF, 32'h01000008, ctrl(1,0,0,2'd0,2'd0,3'd6));
        add_vec("blt",    7'h63, 3'd4, 7'h00, 32'hFFFFFFF8, 32'h01000010, 32'd1,        32'hFFFFFFFF, 32'h01000008, ctrl(0,0,0,2'd0,2'd0,3'd4));
        add_vec("beq",    7'h63, 3'd0, 7'h00, 32'h20,       32'h100,      32'd7,        32'd7,        32'h120,      ctrl(1,0,0,2'd0,2'd0,3'd0));
        add_vec("bne",    7'h63, 3'd1, 7'h00, 32'h20,       32'h100,      32'd7,        32'd7,        32'h120,      ctrl(0,0,0,2'd0,2'd0,3'd1));
        add_vec("bge",    7'h63, 3'd5, 7'h00, 32'h20,       32'h100,      32'hFFFFFFFF, 32'd1,        32'h120,      ctrl(0,0,0,2'd0,2'd0,3'd5));
        add_vec("bgeu",   7'h63, 3'd7, 7'h00, 32'h20,       32'h100,      32'hFFFFFFFF, 32'd1,        32'h120,      ctrl(1,0,0,2'd0,2'd0,3'd7));
        add_vec("br_f3_2",7'h63, 3'd2, 7'h00, 32'h20,       32'h100,      32'd7,        32'd7,        32'h120,      ctrl(0,0,0,2'd0,2'd0,3'd2));
        add_vec("jalr",   7'h67, 3'd0, 7'h00, 32'd2,        32'h500,      32'h01000103, 32'h0,        32'h01000104, ctrl(1,1,0,2'd2,2'd0,3'd0));
        add_vec("jal",    7'h6F, 3'd0, 7'h00, 32'h10,       32'h200,      32'h0,        32'h0,        32'h210,      ctrl(1,1,0,2'd2,2'd0,3'd0));
        add_vec("lbu",    7'h03, 3'd4, 7'h00, 32'd4,        32'h0,        32'h1000,     32'h0,        32'h1004,     ctrl(0,1,0,2'd0,2'd0,3'd4));
        add_vec("lw",     7'h03, 3'd2, 7'h00, 32'hFFFFFFFC, 32'h0,        32'h1000,     32'h0,        32'h0FFC,     ctrl(0,1,0,2'd0,2'd2,3'd2));
        add_vec("sw",     7'h23, 3'd2, 7'h00, 32'd8,        32'h0,        32'h2000,     32'h5555,     32'h2008,     ctrl(0,0,1,2'd0,2'd2,3'd2));
        add_vec("sh",     7'h23, 3'd1, 7'h00, 32'd2,        32'h0,        32'h2000,     32'h5555,     32'h2002,     ctrl(0,0,1,2'd0,2'd1,3'd1));
        add_vec("unknown",7'h7F, 3'd3, 7'h20, 32'h1234,     32'h100,      32'h55,       32'h66,       32'h0,        ctrl(0,0,0,2'd0,2'd0,3'd3));
        add_vec("op_zero",7'h00, 3'd0, 7'h00, 32'h1234,     32'h100,      32'h55,       32'h66,       32'h0,        ZERO_CTRL);

        // Reset state: D holds a JAL but E must stay cleared while reset is high
        reset = 1'b1;
        drive_d(1'b0, 1'b0, 7'h6F, 3'd0, 7'h00, 32'h10, 32'h200);
        drive_rs(32'h3, 32'h3);
        @(posedge clock);
        #1;
        expect_e(32'h0, ZERO_CTRL);
        check_e("reset_state");
        @(negedge clock);
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < n_vec; i++) begin
            drive_d(1'b0, 1'b0, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].imm, vecs[i].pc);
            drive_rs(vecs[i].rs1, vecs[i].rs2);
            @(posedge clock);
            #1;
            expect_e(vecs[i].e_alu, vecs[i].e_ctrl);
            check_e(names[i]);
            @(negedge clock);
        end

        // Stall inserts a bubble, then the held ADD is captured
        drive_d(1'b1, 1'b0, 7'h33, 3'd0, 7'h00, 32'h0, 32'h0);
        drive_rs(32'd5, 32'd7);
        @(posedge clock); #1;
        expect_e(32'h0, ZERO_CTRL);
        check_e("stall_bubble");
        @(negedge clock);
        stall = 1'b0;
        @(posedge clock); #1;
        expect_e(32'd12, ctrl(0,1,0,2'd1,2'd0,3'd0));
        check_e("after_stall");
        @(negedge clock);

        // Flush kills a JAL
        drive_d(1'b0, 1'b1, 7'h6F, 3'd0, 7'h00, 32'h10, 32'h200);
        @(posedge clock); #1;
        expect_e(32'h0, ZERO_CTRL);
        check_e("flush_jal");
        @(negedge clock);

        // Stall and flush together on a store
        drive_d(1'b1, 1'b1, 7'h23, 3'd2, 7'h00, 32'd8, 32'h0);
        drive_rs(32'h2000, 32'h1);
        @(posedge clock); #1;
        expect_e(32'h0, ZERO_CTRL);
        check_e("stall_flush_sw");
        @(negedge clock);

        // Asynchronous reset mid-cycle discards an in-flight JAL
        drive_d(1'b0, 1'b0, 7'h6F, 3'd0, 7'h00, 32'h10, 32'h200);
        @(posedge clock); #1;
        expect_e(32'h210, ctrl(1,1,0,2'd2,2'd0,3'd0));
        check_e("jal_before_reset");
        #2;
        reset = 1'b1;
        #1;
        expect_e(32'h0, ZERO_CTRL);
        check_e("async_reset");
        #1;
        reset = 1'b0;
        @(negedge clock);

        // Store through after reset release
        drive_d(1'b0, 1'b0, 7'h23, 3'd0, 7'h00, 32'h1, 32'h0);
        drive_rs(32'h3000, 32'h0);
        @(posedge clock); #1;
        expect_e(32'h3001, ctrl(0,0,1,2'd0,2'd0,3'd0));
        check_e("sb_after_reset");
        @(negedge clock);

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
